// File: rtl/vc_frame_scheduler.sv
// vc_frame_scheduler: weighted round-robin frame grant for the shared CSI-2 TX link,
// with an inter-frame gap and a watchdog abort for frames that never finish.
module vc_frame_scheduler #(
  parameter int NUM_CAMERAS    = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int GAP_CYCLES     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sched_en,
  input  logic [NUM_CAMERAS-1:0]   cam_req,
  input  logic [NUM_CAMERAS*4-1:0] cam_weight,
  input  logic                     frame_done,
  output logic [NUM_CAMERAS-1:0]   grant,
  output logic [1:0]               grant_vc,
  output logic                     grant_valid,
  output logic                     abort,
  output logic [1:0]               abort_vc,
  output logic [15:0]              timeout_cnt,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, SELECT, ACTIVE, GAP} state_t;
  state_t                 state_q;
  logic [1:0]             ptr_q, grant_vc_q, abort_vc_q;
  logic [3:0]             credit_q;
  logic [15:0]            timer_q, timeout_cnt_q;
  logic [7:0]             gap_q;
  logic [NUM_CAMERAS-1:0] grant_q;
  logic                   grant_valid_q, abort_q, busy_q;
  logic                   keep, found;
  logic [1:0]             win, sel;
  logic [3:0]             wsel;
  // Scan from ptr+NUM down to ptr+1 so the nearest requester after the pointer wins;
  // the pointer camera itself (offset NUM) is the last resort.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = NUM_CAMERAS; k >= 1; k--) begin
      if (cam_req[(int'(ptr_q) + k) % NUM_CAMERAS]) begin
        found = 1'b1;
        win   = 2'((int'(ptr_q) + k) % NUM_CAMERAS);
      end
    end
  end
  assign keep = cam_req[ptr_q] && credit_q != 4'd0;
  assign sel  = keep ? ptr_q : win;
  assign wsel = cam_weight[4*sel +: 4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      credit_q      <= '0;
      timer_q       <= '0;
      gap_q         <= '0;
      grant_q       <= '0;
      grant_vc_q    <= '0;
      grant_valid_q <= 1'b0;
      abort_q       <= 1'b0;
      abort_vc_q    <= '0;
      timeout_cnt_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: if (sched_en && |cam_req) begin
          state_q <= SELECT;
          busy_q  <= 1'b1;
        end
        SELECT: if (keep || found) begin
          state_q       <= ACTIVE;
          ptr_q         <= sel;
          credit_q      <= keep ? credit_q - 4'd1 : (wsel == 4'd0 ? 4'd0 : wsel - 4'd1);
          grant_q       <= NUM_CAMERAS'(1) << sel;
          grant_vc_q    <= sel;
          grant_valid_q <= 1'b1;
          timer_q       <= '0;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        ACTIVE: if (frame_done || timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
          grant_q       <= '0;
          grant_valid_q <= 1'b0;
          gap_q         <= '0;
          state_q       <= GAP_CYCLES == 0 ? IDLE : GAP;
          busy_q        <= GAP_CYCLES != 0;
          if (!frame_done) begin
            abort_q       <= 1'b1;
            abort_vc_q    <= grant_vc_q;
            timeout_cnt_q <= timeout_cnt_q + 16'(timeout_cnt_q != 16'hFFFF);
            credit_q      <= '0;
          end
        end else begin
          timer_q <= timer_q + 16'd1;
        end
        GAP: if (gap_q == 8'(GAP_CYCLES - 1)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          gap_q <= gap_q + 8'd1;
        end
      endcase
    end
  end
  assign grant       = grant_q;
  assign grant_vc    = grant_vc_q;
  assign grant_valid = grant_valid_q;
  assign abort       = abort_q;
  assign abort_vc    = abort_vc_q;
  assign timeout_cnt = timeout_cnt_q;
  assign busy        = busy_q;
endmodule
